instr_fetch_unit: RTL and testbench

//  Consumer side of the program-counter path: owns the fetch pointer and reads instructions from

---
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch pointer, issues one-at-a-time memory reads and buffers
// returned words in a small FIFO for decode. Optional FETCH_PERF_EN adds stall/flush counters.
module instr_fetch_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_addr,
`ifdef FETCH_PERF_EN
   output logic [31:0]       perf_wait_cnt,
   output logic [31:0]       perf_flush_cnt,
`endif
   input  logic              inst_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetchState_t;

   fetchState_t       state, stateNext;
   logic [ADDR_W-1:0] fptr;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  rdPtr, wrPtr;
   logic [DATA_W-1:0] dataMem [DEPTH];
   logic [ADDR_W-1:0] addrMem [DEPTH];

   logic push, pop, issue, reqDone;

   assign inst_valid = (count != '0);
   assign inst_data  = dataMem[rdPtr];
   assign inst_addr  = addrMem[rdPtr];

   // Handshake decisions and next state; a redirect suppresses both the push of an
   // in-flight word and the issue of a new request in the same cycle.
   always_comb begin
      stateNext = state;
      push      = 1'b0;
      issue     = 1'b0;
      reqDone   = 1'b0;
      pop       = inst_valid & inst_ready;
      case (state)
         IDLE: begin
            if (!redirect_valid && (count < FULL_COUNT)) begin
               issue     = 1'b1;
               stateNext = WAIT;
            end
         end
         WAIT: begin
            if (mem_ack) begin
               reqDone   = 1'b1;
               push      = ~redirect_valid;
               stateNext = IDLE;
            end else if (redirect_valid) begin
               stateNext = DISCARD;
            end
         end
         DISCARD: begin
            if (mem_ack) begin
               reqDone   = 1'b1;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Memory request register: address captured from fptr at issue and held until ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else if (issue) begin
         mem_req  <= 1'b1;
         mem_addr <= fptr;
      end else if (reqDone) begin
         mem_req  <= 1'b0;
      end
   end

   // Fetch pointer and FIFO bookkeeping; flush on redirect overrides push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         fptr  <= '0;
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else if (redirect_valid) begin
         fptr  <= {redirect_addr[ADDR_W-1:2], 2'b00};
         count <= '0;
         rdPtr <= '0;
         wrPtr <= '0;
      end else begin
         if (push) begin
            fptr  <= fptr + ADDR_W'(4);
            wrPtr <= wrPtr + PTR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dataMem[wrPtr] <= mem_rdata;
         addrMem[wrPtr] <= fptr;
      end
   end

`ifdef FETCH_PERF_EN
   // Free-running counters for memory stall cycles and redirect cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_wait_cnt  <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (mem_req && !mem_ack) begin
            perf_wait_cnt <= perf_wait_cnt + 32'd1;
         end
         if (redirect_valid) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: a table of per-cycle vectors for streaming fetch,
// plus hand-written sequences for full, redirect, wrap and reset corner cases.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_addr;
   logic        inst_ready;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_wait_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int applied = 0;
   int miscompares = 0;

   instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rdata      (mem_rdata),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_addr      (inst_addr),
`ifdef FETCH_PERF_EN
      .perf_wait_cnt  (perf_wait_cnt),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .inst_ready     (inst_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        ready;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expIAddr;
      logic [31:0] expIData;
   } vector_t;

   vector_t vecs [9];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic ready,
                                input logic redir, input logic [31:0] raddr);
      mem_ack        = ack;
      mem_rdata      = rdata;
      inst_ready     = ready;
      redirect_valid = redir;
      redirect_addr  = raddr;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      step();
      checkOutput("reset mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("reset mem_addr", mem_addr, 32'h0);
      checkOutput("reset inst_valid", {31'b0, inst_valid}, 32'h0);
`ifdef FETCH_PERF_EN
      checkOutput("reset perf_wait_cnt", perf_wait_cnt, 32'h0);
      checkOutput("reset perf_flush_cnt", perf_flush_cnt, 32'h0);
`endif
      reset = 1'b0;
   endtask

   initial begin
      int pushes;
      vecs[0] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
      vecs[1] = '{1'b1, 32'hFFFF0000, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
      vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'hFFFF0000};
      vecs[3] = '{1'b1, 32'hFFFF0004, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0};
      vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'hFFFF0004};
      vecs[5] = '{1'b1, 32'hFFFF0008, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0};
      vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 32'hFFFF0008};
      vecs[7] = '{1'b1, 32'hFFFF000C, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0};
      vecs[8] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 32'hC, 32'hFFFF000C};

      @(negedge clk);

      // Streaming fetch with immediate ack and decode always ready.
      doReset();
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("vec%0d mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].expReq});
         if (vecs[i].expReq)
            checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].expValid});
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d inst_addr", i), inst_addr, vecs[i].expIAddr);
            checkOutput($sformatf("vec%0d inst_data", i), inst_data, vecs[i].expIData);
         end
         applyStimulus(vecs[i].ack, vecs[i].rdata, vecs[i].ready, 1'b0, 32'h0);
         step();
      end

      // Fill the FIFO with decode stalled, then release one entry.
      doReset();
      pushes = 0;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(mem_req, mem_addr ^ 32'hFFFF0000, 1'b0, 1'b0, 32'h0);
         if (mem_req) pushes++;
         step();
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("full push count", pushes, 32'd4);
      checkOutput("full mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("full head addr", inst_addr, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("pop head addr", inst_addr, 32'h4);
      step();
      checkOutput("resume mem_req", {31'b0, mem_req}, 32'h1);
      checkOutput("resume mem_addr", mem_addr, 32'h10);

      // Redirect during a stalled request: word dropped, fetch restarts at target.
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
      step();
      checkOutput("discard mem_req held", {31'b0, mem_req}, 32'h1);
      checkOutput("discard mem_addr held", mem_addr, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      checkOutput("discard mem_req still", {31'b0, mem_req}, 32'h1);
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
      step();
      checkOutput("discard dropped valid", {31'b0, inst_valid}, 32'h0);
      checkOutput("discard ack mem_req", {31'b0, mem_req}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      checkOutput("redir mem_req", {31'b0, mem_req}, 32'h1);
      checkOutput("redir mem_addr", mem_addr, 32'h100);
      applyStimulus(1'b1, 32'hFFFF0100, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("redir inst_valid", {31'b0, inst_valid}, 32'h1);
      checkOutput("redir inst_addr", inst_addr, 32'h100);
      checkOutput("redir inst_data", inst_data, 32'hFFFF0100);
`ifdef FETCH_PERF_EN
      checkOutput("perf_flush_cnt", perf_flush_cnt, 32'd1);
      checkOutput("perf_wait_cnt", perf_wait_cnt, 32'd2);
`endif

      // Redirect coinciding with ack and pop: flush wins.
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("pre-flush inst_valid", {31'b0, inst_valid}, 32'h1);
      checkOutput("pre-flush mem_addr", mem_addr, 32'h4);
      applyStimulus(1'b1, 32'h22222222, 1'b1, 1'b1, 32'h40);
      step();
      checkOutput("flush inst_valid", {31'b0, inst_valid}, 32'h0);
      checkOutput("flush mem_req", {31'b0, mem_req}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step();
      checkOutput("flush next mem_addr", mem_addr, 32'h40);
      applyStimulus(1'b1, 32'h33333333, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("flush first inst_addr", inst_addr, 32'h40);
      checkOutput("flush first inst_data", inst_data, 32'h33333333);

      // Unaligned redirect near the top of the address space and pointer wrap.
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFA);
      step();
      checkOutput("wrap no issue on redirect", {31'b0, mem_req}, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("wrap addr0", mem_addr, 32'hFFFFFFF8);
      applyStimulus(1'b1, 32'hA0, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("wrap head addr", inst_addr, 32'hFFFFFFF8);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("wrap addr1", mem_addr, 32'hFFFFFFFC);
      applyStimulus(1'b1, 32'hA1, 1'b0, 1'b0, 32'h0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("wrap addr2", mem_addr, 32'h0);
      checkOutput("wrap mem_req", {31'b0, mem_req}, 32'h1);

      // Reset asserted while a request is outstanding.
      doReset();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      applyStimulus(1'b1, 32'h44444444, 1'b0, 1'b0, 32'h0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      checkOutput("pre-reset mem_req", {31'b0, mem_req}, 32'h1);
      reset = 1'b1;
      step();
      checkOutput("midreset mem_req", {31'b0, mem_req}, 32'h0);
      checkOutput("midreset inst_valid", {31'b0, inst_valid}, 32'h0);
      reset = 1'b0;
      step();
      checkOutput("restart mem_req", {31'b0, mem_req}, 32'h1);
      checkOutput("restart mem_addr", mem_addr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
